// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter with circular FIFO and back-to-back frames
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock_50MHz,
    input  logic                  reset,
    input  logic [7:0]            din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  tx,
    output logic                  tx_busy
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = $clog2(DIV);
    localparam int NW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_n;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [7:0]            shift_reg;
    logic [2:0]            bit_idx;
    logic [CW-1:0]         baud;
    logic                  baud_end, pop, accept;

    assign full     = count == NW'(DEPTH);
    assign empty    = count == '0;
    assign tx_busy  = state != IDLE;
    assign baud_end = baud == CW'(DIV - 1);
    assign accept   = wr_en && (!full || pop);

    // next state; a pop happens whenever a new frame is entered
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = empty ? IDLE : START;
            START: state_n = baud_end ? DATA : START;
            DATA:  state_n = (baud_end && bit_idx == 3'd7) ? STOP : DATA;
            STOP:  state_n = baud_end ? (empty ? IDLE : START) : STOP;
            default: state_n = IDLE;
        endcase
        pop = (state == IDLE || state == STOP) && state_n == START;
    end

    // state register
    always_ff @(posedge clock_50MHz) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    // FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge clock_50MHz) begin
        if (accept) mem[wr_ptr] <= din;
    end

    // FIFO pointers, occupancy, sticky overflow and serialiser datapath
    always_ff @(posedge clock_50MHz) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
            baud      <= '0;
            tx        <= 1'b1;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                shift_reg <= mem[rd_ptr];
            end
            count    <= count + NW'(accept) - NW'(pop);
            overflow <= overflow || (wr_en && !accept);
            baud     <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
            bit_idx  <= state == START ? 3'd0 : (state == DATA && baud_end) ? bit_idx + 1'b1 : bit_idx;
            tx       <= state == START ? 1'b0 : state == DATA ? shift_reg[bit_idx] : 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench with a byte scoreboard fed by a serial monitor
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       wr_en;
    logic       full, empty, overflow, tx, tx_busy;
    logic [3:0] count;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;
    int rx_total = 0;
    logic [7:0] q[$];

    bit         rx_act = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;

    uart_tx_fifo #(.CLK_HZ(1000), .BAUD(100), .DEPTH_LOG2(3)) dut (
        .clock_50MHz(clk), .reset(rst), .din(din), .wr_en(wr_en),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input bit push);
        din   = b;
        wr_en = 1'b1;
        if (push) q.push_back(b);
        tick;
        wr_en = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((tx_busy || !empty) && n < 3000) begin
            tick;
            n++;
        end
        chk("drain_in_time", 32'(n < 3000), 1);
        repeat (5) tick;
    endtask

    // serial receiver: samples mid-bit and scores each frame against the queue
    always @(negedge clk) begin
        if (rst) rx_act = 0;
        else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 5) chk("start_bit", 32'(tx), 0);
            else if (rx_cnt >= 15 && rx_cnt <= 85 && rx_cnt % 10 == 5) rx_byte = {tx, rx_byte[7:1]};
            else if (rx_cnt == 95) begin
                chk("stop_bit", 32'(tx), 1);
                rx_total++;
                chk("frame_expected", 32'(q.size() > 0), 1);
                if (q.size() > 0) chk("rx_byte", 32'(rx_byte), 32'(q.pop_front()));
            end
            if (rx_cnt == 99) rx_act = 0;
        end
    end

    initial begin
        int w, busy_cyc, base, i;
        bit ok;
        logic [7:0] b;
        rst = 1'b1; wr_en = 1'b0; din = '0;
        repeat (3) tick;
        rst = 1'b0;
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        tick;

        b = 8'h55;
        wr(b, 1);
        chk("single_count_after_write", 32'(count), 1);
        chk("single_tx_idle_n", 32'(tx), 1);
        tick;
        chk("single_busy_n1", 32'(tx_busy), 1);
        chk("single_tx_n1", 32'(tx), 1);
        chk("single_count_n1", 32'(count), 0);
        tick;
        for (int k = 0; k < 100; k++) begin
            chk("single_tx_bit", 32'(k < 10 ? 1'b0 : k < 90 ? b[(k - 10) / 10] : 1'b1), 32'(tx));
            chk("single_busy", 32'(tx_busy), 32'(k < 99));
            tick;
        end
        chk("single_empty_end", 32'(empty), 1);
        chk("single_idle_end", 32'(tx_busy), 0);
        repeat (5) tick;

        wr(8'h41, 1);
        chk("b2b_count1", 32'(count), 1);
        wr(8'h42, 1);
        chk("b2b_count2", 32'(count), 1);
        wr(8'h43, 1);
        chk("b2b_count_peak", 32'(count), 2);
        busy_cyc = 0;
        while (tx_busy && busy_cyc < 400) begin
            busy_cyc++;
            tick;
        end
        chk("b2b_busy_cycles", 32'(busy_cyc), 299);
        repeat (5) tick;
        chk("b2b_all_received", 32'(q.size()), 0);

        wr(8'h10, 1);
        tick; tick;
        for (int k = 0; k < 8; k++) wr(8'h60 + 8'(k), 1);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_count8", 32'(count), 8);
        chk("ovf_not_yet", 32'(overflow), 0);
        wr(8'h99, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count_held", 32'(count), 8);
        drain;
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_first8_only", 32'(q.size()), 0);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("ovf_cleared_by_reset", 32'(overflow), 0);

        wr(8'h20, 1);
        w = cyc;
        tick; tick;
        for (int k = 0; k < 8; k++) wr(8'h70 + 8'(k), 1);
        while (cyc < w + 100) tick;
        chk("coinc_full_before", 32'(full), 1);
        wr(8'h78, 1);
        chk("coinc_count8", 32'(count), 8);
        chk("coinc_no_overflow", 32'(overflow), 0);
        chk("coinc_full_after", 32'(full), 1);
        drain;
        chk("coinc_all_received", 32'(q.size()), 0);

        wr(8'hA5, 1);
        w = cyc;
        wr(8'hB1, 1);
        wr(8'hB2, 1);
        while (cyc < w + 45) tick;
        chk("midrst_in_frame", 32'(tx_busy), 1);
        rst = 1'b1;
        q.delete();
        tick;
        rst = 1'b0;
        chk("midrst_tx", 32'(tx), 1);
        chk("midrst_busy", 32'(tx_busy), 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        ok = 1;
        for (int k = 0; k < 300; k++) begin
            if (tx !== 1'b1 || tx_busy !== 1'b0) ok = 0;
            tick;
        end
        chk("midrst_no_frames", 32'(ok), 1);

        base = rx_total;
        i = 0;
        for (int n = 0; n < 5000 && i < 20; n++) begin
            if (!full) begin
                wr(8'(i), 1);
                i++;
            end else tick;
        end
        chk("wrap_all_written", 32'(i), 20);
        drain;
        chk("wrap_rx_count", 32'(rx_total - base), 20);
        chk("wrap_queue_empty", 32'(q.size()), 0);
        chk("wrap_no_overflow", 32'(overflow), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
